// File: rtl/matrix_pkg.sv
// Purpose: shared encodings and glyph tables for the 8x8 dot-matrix scan interface.
// Latency: n/a (constants and a combinational helper only).
// Backpressure: n/a.
package matrix_pkg;

    typedef enum logic [1:0] {
        ST_GREEN   = 2'd0,
        ST_YELLO   = 2'd1,
        ST_RED     = 2'd2,
        ST_UNKNOWN = 2'd3
    } status_e;

    // Glyphs stored row 0 first, so element 0 is the most significant byte
    // and the packed value lines up with the {row0,...,row7} frame layout.
    localparam logic [0:7][7:0] GLYPH_GREEN = {8'h0C, 8'h0C, 8'h19, 8'h7E,
                                               8'h98, 8'h18, 8'h28, 8'h48};
    localparam logic [0:7][7:0] GLYPH_YELLO = {8'h00, 8'h24, 8'h3C, 8'hBD,
                                               8'hFF, 8'h3C, 8'h3C, 8'h00};
    localparam logic [0:7][7:0] GLYPH_RED   = {8'h18, 8'h18, 8'h3C, 8'h3C,
                                               8'h5A, 8'h18, 8'h18, 8'h18};

    // One-cold row select: row 0 drives bit7 low, row 7 drives bit0 low.
    localparam logic [0:7][7:0] ROW_SEL = {8'h7F, 8'hBF, 8'hDF, 8'hEF,
                                           8'hF7, 8'hFB, 8'hFD, 8'hFE};

    function automatic status_e classify(input logic [63:0] f);
        if (f == GLYPH_GREEN) return ST_GREEN;
        if (f == GLYPH_YELLO) return ST_YELLO;
        if (f == GLYPH_RED)   return ST_RED;
        return ST_UNKNOWN;
    endfunction

endpackage

// File: rtl/matrix_row_decode.sv
// Purpose: decode a one-cold row select into {valid, row index}.
// Latency: combinational.
// Backpressure: none.
// Ports: row_sel (in, 8) one-cold select; row_vld (out) exactly one bit low;
//        row_idx (out, 3) selected row, 0 when row_vld=0.
module matrix_row_decode
    import matrix_pkg::*;
(
    input  logic [7:0] row_sel,
    output logic       row_vld,
    output logic [2:0] row_idx
);

    // Matching against the table rejects both all-ones and multi-zero selects.
    always_comb begin
        row_vld = 1'b0;
        row_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (row_sel == ROW_SEL[i]) begin
                row_vld = 1'b1;
                row_idx = 3'(i);
            end
        end
    end

endmodule

// File: rtl/matrix_scan_capture.sv
// Purpose: rebuild row-scanned 8x8 frames, classify them against the glyphs, flag protocol errors.
// Latency: 2 edges from row 7 on the pins to frame/frame_done/status.
// Backpressure: none; every sampled row is consumed, idle cycles (sample_en=0) are ignored.
// Ports: ani_clk/rst clock and async active-high reset; sample_en, dot_row, dot_col scan inputs;
//        frame last complete frame {row0..row7}; frame_done, row_err, seq_err 1-cycle pulses;
//        status/status_valid stable classification; err_count saturating error count.
module matrix_scan_capture
    import matrix_pkg::*;
#(
    parameter int STABLE_FRAMES = 2,
    parameter int ERR_W         = 8
) (
    input  logic             ani_clk,
    input  logic             rst,
    input  logic             sample_en,
    input  logic [7:0]       dot_row,
    input  logic [7:0]       dot_col,
    output logic [63:0]      frame,
    output logic             frame_done,
    output logic [1:0]       status,
    output logic             status_valid,
    output logic             row_err,
    output logic             seq_err,
    output logic [ERR_W-1:0] err_count
);

    // Counter only needs to reach STABLE_FRAMES; saturating above that is harmless.
    localparam int               CNT_W   = (STABLE_FRAMES < 1) ? 1 : $clog2(STABLE_FRAMES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_THR = CNT_W'(STABLE_FRAMES);

    // Stage 0 input register.
    logic       v_q;
    logic [7:0] row_q;
    logic [7:0] col_q;

    // Stage 1 state.
    logic [7:0]       row_buf [8];
    logic [2:0]       exp_row;
    status_e          last_cls;
    logic [CNT_W-1:0] stab_cnt;

    logic             row_vld;
    logic [2:0]       row_idx;
    logic [63:0]      new_frame;
    status_e          cls;
    logic [CNT_W-1:0] cnt_nxt;
    logic             err_inc;

    matrix_row_decode u_row_decode (
        .row_sel (row_q),
        .row_vld (row_vld),
        .row_idx (row_idx)
    );

    always_ff @(posedge ani_clk or posedge rst) begin
        if (rst) begin
            v_q   <= 1'b0;
            row_q <= 8'hFF;
            col_q <= 8'h00;
        end else begin
            v_q   <= sample_en;
            row_q <= dot_row;
            col_q <= dot_col;
        end
    end

    // Row 7 is still in col_q when the frame completes, so the frame is
    // assembled from the buffer plus the live column byte.
    always_comb begin
        new_frame = {row_buf[0], row_buf[1], row_buf[2], row_buf[3],
                     row_buf[4], row_buf[5], row_buf[6], col_q};
        cls       = classify(new_frame);
        cnt_nxt   = CNT_W'(1);
        if (cls == last_cls) begin
            cnt_nxt = (stab_cnt == CNT_MAX) ? stab_cnt : stab_cnt + CNT_W'(1);
        end
        // A bad select and an out-of-order row are mutually exclusive.
        err_inc   = v_q && (!row_vld || (row_idx != exp_row));
    end

    always_ff @(posedge ani_clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                row_buf[i] <= 8'h00;
            end
            exp_row      <= 3'd0;
            frame        <= 64'd0;
            frame_done   <= 1'b0;
            row_err      <= 1'b0;
            seq_err      <= 1'b0;
            err_count    <= '0;
            status       <= ST_UNKNOWN;
            status_valid <= 1'b0;
            last_cls     <= ST_UNKNOWN;
            stab_cnt     <= '0;
        end else begin
            frame_done <= 1'b0;
            row_err    <= 1'b0;
            seq_err    <= 1'b0;

            if (v_q) begin
                if (!row_vld) begin
                    // Garbled select: abandon the partial frame.
                    row_err <= 1'b1;
                    exp_row <= 3'd0;
                end else if (row_idx == exp_row) begin
                    row_buf[row_idx] <= col_q;
                    exp_row          <= row_idx + 3'd1;
                    if (row_idx == 3'd7) begin
                        frame      <= new_frame;
                        frame_done <= 1'b1;
                        last_cls   <= cls;
                        stab_cnt   <= cnt_nxt;
                        if (cnt_nxt >= CNT_THR) begin
                            status       <= cls;
                            status_valid <= 1'b1;
                        end
                    end
                end else begin
                    // Out of order; a row 0 is still a legitimate frame start.
                    seq_err <= 1'b1;
                    if (row_idx == 3'd0) begin
                        row_buf[0] <= col_q;
                        exp_row    <= 3'd1;
                    end else begin
                        exp_row <= 3'd0;
                    end
                end
            end

            if (err_inc && (err_count != '1)) begin
                err_count <= err_count + ERR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_matrix_scan_capture.sv
// Purpose: directed, self-checking bench for matrix_scan_capture.
// Latency: n/a.
// Backpressure: n/a.
module tb_matrix_scan_capture;

    logic        ani_clk = 1'b0;
    logic        rst;
    logic        sample_en;
    logic [7:0]  dot_row;
    logic [7:0]  dot_col;
    logic [63:0] frame;
    logic        frame_done;
    logic [1:0]  status;
    logic        status_valid;
    logic        row_err;
    logic        seq_err;
    logic [7:0]  err_count;

    matrix_scan_capture #(.STABLE_FRAMES(2), .ERR_W(8)) dut (
        .ani_clk      (ani_clk),
        .rst          (rst),
        .sample_en    (sample_en),
        .dot_row      (dot_row),
        .dot_col      (dot_col),
        .frame        (frame),
        .frame_done   (frame_done),
        .status       (status),
        .status_valid (status_valid),
        .row_err      (row_err),
        .seq_err      (seq_err),
        .err_count    (err_count)
    );

    always #5 ani_clk = ~ani_clk;

    localparam logic [63:0] P_GREEN = 64'h0C0C197E98182848;
    localparam logic [63:0] P_YELLO = 64'h00243CBDFF3C3C00;
    localparam logic [63:0] P_RED   = 64'h18183C3C5A181818;
    localparam logic [63:0] P_FF    = 64'hFFFFFFFFFFFFFFFF;
    localparam logic [63:0] P_T3    = 64'hA55AC33C0FF01248;
    localparam logic [63:0] P_T4    = 64'h0102040810204080;

    typedef struct {
        logic [63:0] pat;
        logic        gaps;
        logic [1:0]  st;
        logic        vld;
    } vec_t;

    vec_t vecs [10];

    int n_chk  = 0;
    int n_pass = 0;
    int fd_cnt = 0;
    int re_cnt = 0;
    int se_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One cycle: count pulses visible now, then present the next inputs.
    task automatic drive(input logic en, input logic [7:0] sel, input logic [7:0] col);
        @(negedge ani_clk);
        if (frame_done === 1'b1) fd_cnt++;
        if (row_err === 1'b1)    re_cnt++;
        if (seq_err === 1'b1)    se_cnt++;
        sample_en = en;
        dot_row   = sel;
        dot_col   = col;
    endtask

    task automatic idle();
        drive(1'b0, 8'hFF, 8'h00);
    endtask

    task automatic send_row(input int r, input logic [63:0] pat);
        logic [7:0] sel;
        sel = ~(8'h80 >> r);
        drive(1'b1, sel, pat[63-8*r -: 8]);
    endtask

    task automatic send_frame(input logic [63:0] pat, input logic gaps);
        for (int r = 0; r < 8; r++) begin
            send_row(r, pat);
            if (gaps) repeat ((r % 3) + 1) idle();
        end
        idle();
        idle();
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        sample_en = 1'b0;
        dot_row   = 8'hFF;
        dot_col   = 8'h00;
        repeat (2) @(negedge ani_clk);
        rst = 1'b0;
    endtask

    initial begin
        int fd0;
        int re0;
        int se0;

        vecs[0] = '{P_RED,   1'b0, 2'd3, 1'b0};
        vecs[1] = '{P_RED,   1'b0, 2'd2, 1'b1};
        vecs[2] = '{P_GREEN, 1'b0, 2'd2, 1'b1};
        vecs[3] = '{P_GREEN, 1'b0, 2'd0, 1'b1};
        vecs[4] = '{P_YELLO, 1'b0, 2'd0, 1'b1};
        vecs[5] = '{P_YELLO, 1'b0, 2'd1, 1'b1};
        vecs[6] = '{P_FF,    1'b0, 2'd1, 1'b1};
        vecs[7] = '{P_FF,    1'b0, 2'd3, 1'b1};
        vecs[8] = '{P_RED,   1'b1, 2'd3, 1'b1};
        vecs[9] = '{P_RED,   1'b1, 2'd2, 1'b1};

        do_reset();
        check("rst_frame",        frame,        64'd0);
        check("rst_frame_done",   frame_done,   64'd0);
        check("rst_status",       status,       64'd3);
        check("rst_status_valid", status_valid, 64'd0);
        check("rst_row_err",      row_err,      64'd0);
        check("rst_seq_err",      seq_err,      64'd0);
        check("rst_err_count",    err_count,    64'd0);

        // Latency: row 7 presented, frame_done one edge later is still low, then high.
        for (int r = 0; r < 8; r++) send_row(r, P_RED);
        idle();
        check("lat_fd_early", frame_done, 64'd0);
        idle();
        check("lat_fd",       frame_done,   64'd1);
        check("lat_frame",    frame,        P_RED);
        check("lat_valid",    status_valid, 64'd0);
        idle();
        check("lat_fd_pulse", frame_done,   64'd0);

        // Table: frame sequence with expected stable status after each frame.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            fd0 = fd_cnt;
            send_frame(vecs[i].pat, vecs[i].gaps);
            check($sformatf("vec%0d_fd", i),     64'(fd_cnt - fd0), 64'd1);
            check($sformatf("vec%0d_frame", i),  frame,             vecs[i].pat);
            check($sformatf("vec%0d_status", i), status,            64'(vecs[i].st));
            check($sformatf("vec%0d_valid", i),  status_valid,      64'(vecs[i].vld));
            check($sformatf("vec%0d_errs", i),   err_count,         64'd0);
        end

        // Malformed row select mid-frame.
        fd0 = fd_cnt; re0 = re_cnt; se0 = se_cnt;
        for (int r = 0; r < 3; r++) send_row(r, P_T3);
        drive(1'b1, 8'b0011_1111, 8'h55);
        idle();
        check("t3_row_err_early", row_err,   64'd0);
        idle();
        check("t3_row_err",       row_err,   64'd1);
        check("t3_err_count",     err_count, 64'd1);
        idle();
        check("t3_row_err_pulse", row_err,   64'd0);
        send_frame(P_T3, 1'b0);
        check("t3_fd",      64'(fd_cnt - fd0), 64'd1);
        check("t3_frame",   frame,             P_T3);
        check("t3_re_cnt",  64'(re_cnt - re0), 64'd1);
        check("t3_se_cnt",  64'(se_cnt - se0), 64'd0);

        // Out-of-order row 5 after rows 0..2.
        fd0 = fd_cnt; se0 = se_cnt;
        for (int r = 0; r < 3; r++) send_row(r, 64'hDEADBEEFCAFEF00D);
        send_row(5, 64'hDEADBEEFCAFEF00D);
        idle();
        idle();
        check("t4_seq_err",   seq_err,   64'd1);
        check("t4_err_count", err_count, 64'd2);
        send_frame(P_T4, 1'b0);
        check("t4_fd",     64'(fd_cnt - fd0), 64'd1);
        check("t4_frame",  frame,             P_T4);
        check("t4_se_cnt", 64'(se_cnt - se0), 64'd1);

        // Asynchronous reset during row 4.
        for (int r = 0; r < 4; r++) send_row(r, P_RED);
        send_row(4, P_RED);
        #2 rst = 1'b1;
        #1;
        check("t5_rst_frame",  frame,        64'd0);
        check("t5_rst_status", status,       64'd3);
        check("t5_rst_valid",  status_valid, 64'd0);
        check("t5_rst_errs",   err_count,    64'd0);
        check("t5_rst_fd",     frame_done,   64'd0);
        @(negedge ani_clk);
        rst = 1'b0;
        fd0 = fd_cnt;
        for (int r = 5; r < 8; r++) send_row(r, P_RED);
        idle();
        idle();
        check("t5_no_stray_fd", 64'(fd_cnt - fd0), 64'd0);
        check("t5_frame_kept",  frame,             64'd0);
        send_frame(P_RED, 1'b0);
        check("t5_refd",    64'(fd_cnt - fd0), 64'd1);
        check("t5_reframe", frame,             P_RED);
        check("t5_restat",  status,            64'd3);

        // Error counter saturation.
        re0 = re_cnt;
        repeat (300) drive(1'b1, 8'hFF, 8'h00);
        idle();
        idle();
        idle();
        check("t6_re_cnt",    64'(re_cnt - re0), 64'd300);
        check("t6_err_sat",   err_count,         64'hFF);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
